// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between instruction fetch
// and data load/store. Each access lasts MEM_LAT cycles and ends with a one-cycle ready pulse.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_dm_q, last_dm_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic if_elig_s;
    logic dm_elig_s;
    logic grant_if_s;
    logic grant_dm_s;

    // A requester in its ready cycle is already moving on, so its stale req is ignored.
    assign if_elig_s  = if_req & ~if_ready_q;
    assign dm_elig_s  = dm_req & ~dm_ready_q;
    assign grant_if_s = if_elig_s & (~dm_elig_s | last_dm_q);
    assign grant_dm_s = dm_elig_s & ~grant_if_s;

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dm_d   = last_dm_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_dm_s) begin
                    state_d     = DM_ACC;
                    cnt_d       = CNT_INIT;
                    last_dm_d   = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if_s) begin
                    state_d    = IF_ACC;
                    cnt_d      = CNT_INIT;
                    last_dm_d  = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_ACC, DM_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == IF_ACC) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 4'd0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_dm_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dm_q   <= last_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (MEM_LAT=2) with a tiny address-keyed memory model.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_checks;
    int n_fail;

    int          g;
    int          n_dm;
    int          n_if;
    logic        prev_en;
    logic [31:0] g_addr [6];
    logic        g_we   [6];
    logic [31:0] exp_addr [6];
    logic        exp_we   [6];

    unified_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .MEM_LAT(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h8C01_0004;
        else return ~a;
    endfunction

    assign mem_rdata = mem_en ? mem_model(mem_addr) : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0555;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0AAA;
        dm_wdata = 32'h1234_5678;

        // Reset held with requests asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mem_en",    32'(mem_en),   32'd0);
            check("rst_mem_we",    32'(mem_we),   32'd0);
            check("rst_mem_addr",  mem_addr,      32'd0);
            check("rst_mem_wdata", mem_wdata,     32'd0);
            check("rst_if_ready",  32'(if_ready), 32'd0);
            check("rst_dm_ready",  32'(dm_ready), 32'd0);
            check("rst_if_rdata",  if_rdata,      32'd0);
            check("rst_dm_rdata",  dm_rdata,      32'd0);
        end
        rst_n  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        check("idle_mem_en", 32'(mem_en), 32'd0);

        // Lone fetch
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        #1;
        check("lf_stall_t0", 32'(stall_if), 32'd1);
        tick();
        check("lf_en_t1",    32'(mem_en),   32'd1);
        check("lf_addr_t1",  mem_addr,      32'h0000_0100);
        check("lf_we_t1",    32'(mem_we),   32'd0);
        check("lf_stall_t1", 32'(stall_if), 32'd1);
        tick();
        check("lf_en_t2",    32'(mem_en),   32'd1);
        check("lf_stall_t2", 32'(stall_if), 32'd1);
        check("lf_rdy_t2",   32'(if_ready), 32'd0);
        tick();
        check("lf_en_t3",    32'(mem_en),   32'd0);
        check("lf_rdy_t3",   32'(if_ready), 32'd1);
        check("lf_rdata_t3", if_rdata,      32'h8C01_0004);
        check("lf_stall_t3", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();
        check("lf_rdy_t4",   32'(if_ready), 32'd0);
        check("lf_hold_t4",  if_rdata,      32'h8C01_0004);
        check("lf_en_t4",    32'(mem_en),   32'd0);

        // Collision: load wins first, fetch follows in the load's ready cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0040;
        tick();
        check("col_en_t1",    32'(mem_en),    32'd1);
        check("col_addr_t1",  mem_addr,       32'h0000_0040);
        check("col_we_t1",    32'(mem_we),    32'd0);
        check("col_sif_t1",   32'(stall_if),  32'd1);
        check("col_smem_t1",  32'(stall_mem), 32'd1);
        tick();
        tick();
        check("col_dmrdy_t3", 32'(dm_ready),  32'd1);
        check("col_dmdat_t3", dm_rdata,       32'hFFFF_FFBF);
        check("col_en_t3",    32'(mem_en),    32'd0);
        check("col_smem_t3",  32'(stall_mem), 32'd0);
        check("col_sif_t3",   32'(stall_if),  32'd1);
        dm_req = 1'b0;
        tick();
        check("col_en_t4",    32'(mem_en),    32'd1);
        check("col_addr_t4",  mem_addr,       32'h0000_0200);
        check("col_dmrdy_t4", 32'(dm_ready),  32'd0);
        tick();
        tick();
        check("col_ifrdy_t6", 32'(if_ready),  32'd1);
        check("col_ifdat_t6", if_rdata,       32'hFFFF_FDFF);
        if_req = 1'b0;
        tick();

        // Fairness: three stores against three fetches must interleave
        exp_addr = '{32'h10, 32'h300, 32'h14, 32'h304, 32'h18, 32'h308};
        exp_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        g        = 0;
        n_dm     = 0;
        n_if     = 0;
        prev_en  = mem_en;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0010;
        dm_wdata = 32'h1111_0000;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0300;
        for (int c = 0; c < 60 && (dm_req || if_req); c++) begin
            tick();
            if (mem_en && !prev_en && g < 6) begin
                g_addr[g] = mem_addr;
                g_we[g]   = mem_we;
                g++;
            end
            prev_en = mem_en;
            if (dm_ready) begin
                n_dm++;
                if (n_dm == 3) dm_req = 1'b0;
                else begin
                    dm_addr  = dm_addr + 32'd4;
                    dm_wdata = dm_wdata + 32'd1;
                end
            end
            if (if_ready) begin
                n_if++;
                if (n_if == 3) if_req = 1'b0;
                else if_addr = if_addr + 32'd4;
            end
        end
        check("fair_dm_done", 32'(n_dm), 32'd3);
        check("fair_if_done", 32'(n_if), 32'd3);
        check("fair_grants",  32'(g),    32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < g) begin
                check($sformatf("fair_addr%0d", k), g_addr[k],     exp_addr[k]);
                check($sformatf("fair_we%0d", k),   32'(g_we[k]),  32'(exp_we[k]));
            end
        end
        tick();

        // Store with no competing fetch
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0010;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        check("st_en_t1",    32'(mem_en),   32'd1);
        check("st_we_t1",    32'(mem_we),   32'd1);
        check("st_addr_t1",  mem_addr,      32'h0000_0010);
        check("st_wdata_t1", mem_wdata,     32'hDEAD_BEEF);
        tick();
        check("st_we_t2",    32'(mem_we),   32'd1);
        check("st_wdata_t2", mem_wdata,     32'hDEAD_BEEF);
        tick();
        check("st_rdy_t3",   32'(dm_ready), 32'd1);
        check("st_we_t3",    32'(mem_we),   32'd0);
        check("st_en_t3",    32'(mem_en),   32'd0);
        check("st_ifrdy_t3", 32'(if_ready), 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        check("st_rdy_t4",   32'(dm_ready), 32'd0);

        // Load withdrawn mid-access still completes once
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0080;
        tick();
        dm_req = 1'b0;
        check("wd_en_t1",    32'(mem_en),   32'd1);
        tick();
        tick();
        check("wd_rdy_t3",   32'(dm_ready), 32'd1);
        check("wd_dat_t3",   dm_rdata,      32'hFFFF_FF7F);
        tick();
        check("wd_rdy_t4",   32'(dm_ready), 32'd0);

        // Reset during an access abandons it without a ready pulse
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        tick();
        check("rm_en_t1",    32'(mem_en),   32'd1);
        rst_n = 1'b0;
        tick();
        check("rm_en_t2",    32'(mem_en),   32'd0);
        check("rm_addr_t2",  mem_addr,      32'd0);
        check("rm_rdy_t2",   32'(if_ready), 32'd0);
        check("rm_rdata_t2", if_rdata,      32'd0);
        rst_n  = 1'b1;
        if_req = 1'b0;
        tick();
        check("rm_rdy_t3",   32'(if_ready), 32'd0);
        check("rm_en_t3",    32'(mem_en),   32'd0);
        tick();
        check("rm_rdy_t4",   32'(if_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
